heap_pqueue: RTL and testbench

HEAP_PQUEUE -- requirements
Module: heap_pqueue

---
 rtl/heap_pkg.sv | 19 +
 rtl/heap_cmp.sv | 16 +
 rtl/heap_pqueue.sv | 191 +++++++++++++++++++
 tb/tb_heap_pqueue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap priority queue: FSM state encoding and
// the width helper used to size the occupancy counter and index registers.
package heap_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SIFT_UP   = 2'd1;
  localparam logic [1:0] ST_SIFT_DOWN = 2'd2;

  // Smallest n such that 2**n >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/heap_cmp.sv
// Ordering primitive of the heap: a_better is high when a must sit above b.
// Signed compare; equal values are never better, which keeps sifts stable
// and stops them early on duplicates.
module heap_cmp #(
  parameter int WIDTH    = 32,
  parameter int MAX_MODE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_better
);

  assign a_better = (MAX_MODE != 0) ? ($signed(a) > $signed(b))
                                    : ($signed(a) < $signed(b));

endmodule

// File: rtl/heap_pqueue.sv
// Binary-heap priority queue. Push appends at the tail and sifts up; pop
// moves the tail to the root and sifts down; push+pop together replaces the
// root and sifts down. One swap per cycle, handshakes only while IDLE.
module heap_pqueue
  import heap_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int MAX_MODE = 0
) (
  input  logic                       system1000,
  input  logic                       system1000_rstn,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [clog2(DEPTH+1)-1:0]  count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int AW = clog2(DEPTH);
  // Child indices reach 2*DEPTH, so they carry two extra bits.
  localparam int XW = AW + 2;

  logic [1:0]       state, state_nxt;
  logic [AW-1:0]    idx, idx_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] heap [DEPTH];

  logic             we_a, we_b;
  logic [AW-1:0]    wa_a, wa_b;
  logic [WIDTH-1:0] wd_a, wd_b;

  logic             push_fire, pop_fire;
  logic [AW-1:0]    parent, last;
  logic [XW-1:0]    left_x, right_x, count_x;
  logic             left_ok, right_ok;
  logic [WIDTH-1:0] cur_val, par_val, left_val, right_val, last_val, best_val;
  logic             up_better, left_better, right_better;
  logic             pick_left, pick_right;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == {CW{1'b0}});
  assign in_ready  = (state == ST_IDLE) && !full;
  assign out_valid = (state == ST_IDLE) && !empty;
  assign out_data  = heap[0];

  assign push_fire = in_valid && in_ready;
  assign pop_fire  = out_valid && out_ready;

  assign parent  = (idx - AW'(1)) >> 1;
  // For a power-of-two DEPTH a full count wraps to 0 in the low bits, and
  // subtracting one still lands on DEPTH-1.
  assign last    = count[AW-1:0] - AW'(1);
  assign left_x  = {1'b0, idx, 1'b1};
  assign right_x = left_x + XW'(1);
  assign count_x = XW'(count);
  // Children past the occupied region hold stale data and must be ignored.
  assign left_ok  = (left_x < count_x);
  assign right_ok = (right_x < count_x);

  assign cur_val   = heap[idx];
  assign par_val   = heap[parent];
  assign left_val  = heap[left_x[AW-1:0]];
  assign right_val = heap[right_x[AW-1:0]];
  assign last_val  = heap[last];

  heap_cmp #(.WIDTH(WIDTH), .MAX_MODE(MAX_MODE)) u_cmp_up (
    .a(cur_val), .b(par_val), .a_better(up_better)
  );

  heap_cmp #(.WIDTH(WIDTH), .MAX_MODE(MAX_MODE)) u_cmp_left (
    .a(left_val), .b(cur_val), .a_better(left_better)
  );

  assign pick_left = left_ok && left_better;
  assign best_val  = pick_left ? left_val : cur_val;

  // Right wins only if strictly better than the current winner, so a tie
  // between the children keeps the left one.
  heap_cmp #(.WIDTH(WIDTH), .MAX_MODE(MAX_MODE)) u_cmp_right (
    .a(right_val), .b(best_val), .a_better(right_better)
  );

  assign pick_right = right_ok && right_better;

  // Next-state decode plus the two heap write ports (a swap needs both).
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    count_nxt = count;
    we_a      = 1'b0;
    wa_a      = idx;
    wd_a      = cur_val;
    we_b      = 1'b0;
    wa_b      = parent;
    wd_b      = par_val;
    case (state)
      ST_IDLE: begin
        if (push_fire && pop_fire) begin
          we_a      = 1'b1;
          wa_a      = {AW{1'b0}};
          wd_a      = in_data;
          idx_nxt   = {AW{1'b0}};
          state_nxt = ST_SIFT_DOWN;
        end else if (push_fire) begin
          we_a      = 1'b1;
          wa_a      = count[AW-1:0];
          wd_a      = in_data;
          idx_nxt   = count[AW-1:0];
          count_nxt = count + CW'(1);
          state_nxt = ST_SIFT_UP;
        end else if (pop_fire) begin
          we_a      = 1'b1;
          wa_a      = {AW{1'b0}};
          wd_a      = last_val;
          idx_nxt   = {AW{1'b0}};
          count_nxt = count - CW'(1);
          state_nxt = (count == CW'(1)) ? ST_IDLE : ST_SIFT_DOWN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SIFT_UP: begin
        if ((idx != {AW{1'b0}}) && up_better) begin
          we_a    = 1'b1;
          wa_a    = idx;
          wd_a    = par_val;
          we_b    = 1'b1;
          wa_b    = parent;
          wd_b    = cur_val;
          idx_nxt = parent;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SIFT_DOWN: begin
        if (pick_right) begin
          we_a    = 1'b1;
          wa_a    = idx;
          wd_a    = right_val;
          we_b    = 1'b1;
          wa_b    = right_x[AW-1:0];
          wd_b    = cur_val;
          idx_nxt = right_x[AW-1:0];
        end else if (pick_left) begin
          we_a    = 1'b1;
          wa_a    = idx;
          wd_a    = left_val;
          we_b    = 1'b1;
          wa_b    = left_x[AW-1:0];
          wd_b    = cur_val;
          idx_nxt = left_x[AW-1:0];
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any sift in progress.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state <= ST_IDLE;
      idx   <= {AW{1'b0}};
      count <= {CW{1'b0}};
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      count <= count_nxt;
    end
  end

  // Heap storage; contents past count are don't-care, so no reset.
  always_ff @(posedge system1000) begin
    if (we_a) begin
      heap[wa_a] <= wd_a;
    end
    if (we_b) begin
      heap[wa_b] <= wd_b;
    end
  end

endmodule

// File: tb/tb_heap_pqueue.sv
// Directed bench for heap_pqueue: a min-heap and a max-heap instance,
// scenario tasks with hand-computed expected values.
module tb_heap_pqueue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic        mn_in_valid, mn_in_ready, mn_out_valid, mn_out_ready, mn_full, mn_empty;
  logic [31:0] mn_in_data, mn_out_data;
  logic [3:0]  mn_count;
  logic        mx_in_valid, mx_in_ready, mx_out_valid, mx_out_ready, mx_full, mx_empty;
  logic [31:0] mx_in_data, mx_out_data;
  logic [3:0]  mx_count;

  always #5 clk = ~clk;

  heap_pqueue #(.WIDTH(32), .DEPTH(8), .MAX_MODE(0)) dut_min (
    .system1000(clk), .system1000_rstn(rst_n),
    .in_valid(mn_in_valid), .in_data(mn_in_data), .in_ready(mn_in_ready),
    .out_valid(mn_out_valid), .out_data(mn_out_data), .out_ready(mn_out_ready),
    .count(mn_count), .full(mn_full), .empty(mn_empty)
  );

  heap_pqueue #(.WIDTH(32), .DEPTH(8), .MAX_MODE(1)) dut_max (
    .system1000(clk), .system1000_rstn(rst_n),
    .in_valid(mx_in_valid), .in_data(mx_in_data), .in_ready(mx_in_ready),
    .out_valid(mx_out_valid), .out_data(mx_out_data), .out_ready(mx_out_ready),
    .count(mx_count), .full(mx_full), .empty(mx_empty)
  );

  // Wait until the selected queue is back in IDLE; cycles = edges spent.
  task automatic wait_idle(input bit mx, input string tag, output int cycles);
    cycles = 0;
    while (!(mx ? (mx_in_ready || mx_out_valid) : (mn_in_ready || mn_out_valid))) begin
      if (cycles >= 20) begin
        n_cmp++; n_fail++;
        $display("FAIL %s: timeout waiting for idle after %0d cycles, required <= 20", tag, cycles);
        return;
      end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic do_push(input bit mx, input logic [31:0] v, output int cycles);
    int guard = 0;
    cycles = 0;
    while (!(mx ? mx_in_ready : mn_in_ready)) begin
      if (guard >= 20) begin
        n_cmp++; n_fail++;
        $display("FAIL push_ready: timeout waiting for in_ready, required within 20 cycles");
        return;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (mx) begin mx_in_valid = 1'b1; mx_in_data = v; end
    else begin mn_in_valid = 1'b1; mn_in_data = v; end
    @(posedge clk); #1;
    mx_in_valid = 1'b0;
    mn_in_valid = 1'b0;
    wait_idle(mx, "push_idle", cycles);
  endtask

  task automatic do_pop(input bit mx, output logic [31:0] v);
    int guard = 0;
    int cyc;
    v = 32'd0;
    while (!(mx ? mx_out_valid : mn_out_valid)) begin
      if (guard >= 20) begin
        n_cmp++; n_fail++;
        $display("FAIL pop_valid: timeout waiting for out_valid, required within 20 cycles");
        return;
      end
      @(posedge clk); #1;
      guard++;
    end
    v = mx ? mx_out_data : mn_out_data;
    if (mx) mx_out_ready = 1'b1;
    else mn_out_ready = 1'b1;
    @(posedge clk); #1;
    mx_out_ready = 1'b0;
    mn_out_ready = 1'b0;
    wait_idle(mx, "pop_idle", cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++; if (mn_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", mn_count); end
    n_cmp++; if (mn_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", mn_empty); end
    n_cmp++; if (mn_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", mn_full); end
    n_cmp++; if (mn_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", mn_in_ready); end
    n_cmp++; if (mn_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", mn_out_valid); end
  endtask

  task automatic test_min_order();
    int pv[4] = '{5, 3, 7, 1};
    int ev[4] = '{1, 3, 5, 7};
    int cyc;
    logic [31:0] got;
    for (int i = 0; i < 4; i++) do_push(1'b0, 32'(pv[i]), cyc);
    n_cmp++; if (mn_out_data !== 32'd1) begin n_fail++; $display("FAIL min_top: got %0d expected 1", $signed(mn_out_data)); end
    n_cmp++; if (mn_count !== 4'd4) begin n_fail++; $display("FAIL min_count: got %0d expected 4", mn_count); end
    for (int i = 0; i < 4; i++) begin
      do_pop(1'b0, got);
      n_cmp++; if (got !== 32'(ev[i])) begin n_fail++; $display("FAIL min_pop%0d: got %0d expected %0d", i, $signed(got), ev[i]); end
    end
    n_cmp++; if (mn_empty !== 1'b1) begin n_fail++; $display("FAIL min_empty: got %b expected 1", mn_empty); end
  endtask

  task automatic test_max_mode();
    int pv[4] = '{-2, 9, 0, 9};
    int ev[4] = '{9, 9, 0, -2};
    int cyc;
    logic [31:0] got;
    for (int i = 0; i < 4; i++) do_push(1'b1, 32'(pv[i]), cyc);
    n_cmp++; if (mx_out_data !== 32'd9) begin n_fail++; $display("FAIL max_top: got %0d expected 9", $signed(mx_out_data)); end
    for (int i = 0; i < 4; i++) begin
      do_pop(1'b1, got);
      n_cmp++; if (got !== 32'(ev[i])) begin n_fail++; $display("FAIL max_pop%0d: got %0d expected %0d", i, $signed(got), ev[i]); end
    end
    n_cmp++; if (mx_empty !== 1'b1) begin n_fail++; $display("FAIL max_empty: got %b expected 1", mx_empty); end
  endtask

  task automatic test_full();
    int pv[8] = '{12, 4, 9, 15, 1, 7, 20, 3};
    int ev[8] = '{1, 3, 4, 7, 9, 12, 15, 20};
    int cyc;
    logic [31:0] got;
    for (int i = 0; i < 8; i++) do_push(1'b0, 32'(pv[i]), cyc);
    n_cmp++; if (mn_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", mn_full); end
    n_cmp++; if (mn_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", mn_in_ready); end
    mn_in_valid = 1'b1;
    mn_in_data  = 32'hFFFF_FF9C;
    repeat (2) begin @(posedge clk); #1; end
    mn_in_valid = 1'b0;
    n_cmp++; if (mn_count !== 4'd8) begin n_fail++; $display("FAIL full_ignored_count: got %0d expected 8", mn_count); end
    n_cmp++; if (mn_out_data !== 32'd1) begin n_fail++; $display("FAIL full_ignored_top: got %0d expected 1", $signed(mn_out_data)); end
    for (int i = 0; i < 8; i++) begin
      do_pop(1'b0, got);
      n_cmp++; if (got !== 32'(ev[i])) begin n_fail++; $display("FAIL full_pop%0d: got %0d expected %0d", i, $signed(got), ev[i]); end
      if (i == 0) begin
        n_cmp++; if (mn_full !== 1'b0) begin n_fail++; $display("FAIL full_after_pop: got %b expected 0", mn_full); end
        n_cmp++; if (mn_count !== 4'd7) begin n_fail++; $display("FAIL full_after_pop_count: got %0d expected 7", mn_count); end
      end
    end
  endtask

  task automatic test_sift_depth();
    int cyc;
    logic [31:0] got;
    for (int v = 8; v >= 1; v--) do_push(1'b0, 32'(v), cyc);
    n_cmp++; if (cyc > 4 || cyc < 1) begin n_fail++; $display("FAIL sift_cycles: got %0d expected 1..4", cyc); end
    n_cmp++; if (mn_out_data !== 32'd1) begin n_fail++; $display("FAIL sift_top: got %0d expected 1", $signed(mn_out_data)); end
    for (int i = 1; i <= 8; i++) begin
      do_pop(1'b0, got);
      n_cmp++; if (got !== 32'(i)) begin n_fail++; $display("FAIL sift_pop%0d: got %0d expected %0d", i, $signed(got), i); end
    end
  endtask

  task automatic test_replace();
    int cyc;
    logic [31:0] got;
    do_push(1'b0, 32'd2, cyc);
    do_push(1'b0, 32'd4, cyc);
    do_push(1'b0, 32'd6, cyc);
    got = mn_out_data;
    mn_in_valid  = 1'b1;
    mn_in_data   = 32'd5;
    mn_out_ready = 1'b1;
    @(posedge clk); #1;
    mn_in_valid  = 1'b0;
    mn_out_ready = 1'b0;
    wait_idle(1'b0, "replace_idle", cyc);
    n_cmp++; if (got !== 32'd2) begin n_fail++; $display("FAIL replace_ret: got %0d expected 2", $signed(got)); end
    n_cmp++; if (mn_count !== 4'd3) begin n_fail++; $display("FAIL replace_count: got %0d expected 3", mn_count); end
    for (int i = 0; i < 3; i++) begin
      do_pop(1'b0, got);
      n_cmp++; if (got !== 32'(4 + i)) begin n_fail++; $display("FAIL replace_pop%0d: got %0d expected %0d", i, $signed(got), 4 + i); end
    end
  endtask

  task automatic test_reset_mid_sift();
    int cyc;
    do_push(1'b0, 32'd3, cyc);
    do_push(1'b0, 32'd1, cyc);
    do_push(1'b0, 32'd2, cyc);
    mn_out_ready = 1'b1;
    @(posedge clk); #1;
    mn_out_ready = 1'b0;
    n_cmp++; if (mn_in_ready !== 1'b0 || mn_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midsift_busy: got in_ready=%b out_valid=%b expected 0 0", mn_in_ready, mn_out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mn_count !== 4'd0) begin n_fail++; $display("FAIL midsift_rst_count: got %0d expected 0", mn_count); end
    n_cmp++; if (mn_out_valid !== 1'b0) begin n_fail++; $display("FAIL midsift_rst_out_valid: got %b expected 0", mn_out_valid); end
    n_cmp++; if (mn_in_ready !== 1'b1) begin n_fail++; $display("FAIL midsift_rst_in_ready: got %b expected 1", mn_in_ready); end
    n_cmp++; if (mn_empty !== 1'b1) begin n_fail++; $display("FAIL midsift_rst_empty: got %b expected 1", mn_empty); end
    @(negedge clk);
    rst_n = 1'b1;
    do_push(1'b0, 32'd42, cyc);
    n_cmp++; if (mn_out_data !== 32'd42) begin n_fail++; $display("FAIL post_rst_top: got %0d expected 42", $signed(mn_out_data)); end
    n_cmp++; if (mn_count !== 4'd1) begin n_fail++; $display("FAIL post_rst_count: got %0d expected 1", mn_count); end
  endtask

  initial begin
    mn_in_valid = 1'b0; mn_in_data = 32'd0; mn_out_ready = 1'b0;
    mx_in_valid = 1'b0; mx_in_data = 32'd0; mx_out_ready = 1'b0;
    test_reset();
    test_min_order();
    test_max_mode();
    test_full();
    test_sift_depth();
    test_replace();
    test_reset_mid_sift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
